rf_param_dump: RTL and testbench

Parametrised successor register file for the monocycle processor: configurable data width and register count, two asynchronous read ports, one synchronous write port, hardwired-zero register 0 and synchronous clear on reset. It adds a handshaked sequential dump engine that streams every register out one per accepted beat for testbench/debug observation. It sits between decode (read addresses), writeback (write port) and the debug/trace logic (dump port).

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_dump_ctrl.sv | 64 ++++++
 rtl/rf_param_dump.sv | 67 ++++++
 tb/tb_rf_param_dump.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the parametrised register file and its dump engine.
package rf_pkg;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_SCAN,
    RF_DONE
  } rf_state_e;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREGS_DEF = 32;

endpackage

// File: rtl/rf_dump_ctrl.sv
// Sequential dump engine: walks register indices 0..NREGS-1 under a valid/ready handshake.
module rf_dump_ctrl
  import rf_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ready,
  output logic          valid,
  output logic [AW-1:0] idx,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_e     state, state_next;
  logic [AW-1:0] idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // The index only advances on an accepted beat and stops at LAST, so it never wraps.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    valid      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      RF_IDLE: begin
        if (start) begin
          state_next = RF_SCAN;
          idx_next   = '0;
        end
      end
      RF_SCAN: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready) begin
          if (idx == LAST) state_next = RF_DONE;
          else             idx_next   = idx + AW'(1);
        end
      end
      RF_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = RF_IDLE;
      end
      default: state_next = RF_IDLE;
    endcase
  end

endmodule

// File: rtl/rf_param_dump.sv
// Parametrised register file (2 async reads, 1 sync write, r0 hardwired to zero) with a dump port.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read and dump outputs.
module rf_param_dump
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DEF,
  parameter int NREGS = RF_NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   RFregister1,
  input  logic [AW-1:0]   RFregister2,
  input  logic [AW-1:0]   RFdestination_register,
  input  logic [XLEN-1:0] RFwrite_data,
  input  logic            RFwenable,
  output logic [XLEN-1:0] RFdata1,
  output logic [XLEN-1:0] RFdata2,
  input  logic            RFdump_start,
  input  logic            RFdump_ready,
  output logic            RFdump_valid,
  output logic [AW-1:0]   RFdump_idx,
  output logic [XLEN-1:0] RFdump_data,
  output logic            RFdump_busy,
  output logic            RFdump_done
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = RFwenable && (RFdestination_register != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[RFdestination_register] <= RFwrite_data;
    end
  end

  rf_dump_ctrl #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_dump_ctrl (
    .clk  (clk),
    .rst  (rst),
    .start(RFdump_start),
    .ready(RFdump_ready),
    .valid(RFdump_valid),
    .idx  (RFdump_idx),
    .busy (RFdump_busy),
    .done (RFdump_done)
  );

  // Dump data is live from the array, never snapshotted at start.
  always_comb begin
    RFdata1     = (RFregister1 == '0) ? '0 : regs[RFregister1];
    RFdata2     = (RFregister2 == '0) ? '0 : regs[RFregister2];
    RFdump_data = (RFdump_idx  == '0) ? '0 : regs[RFdump_idx];
`ifdef RF_BYPASS_EN
    if (wr_en && (RFdestination_register == RFregister1)) RFdata1     = RFwrite_data;
    if (wr_en && (RFdestination_register == RFregister2)) RFdata2     = RFwrite_data;
    if (wr_en && (RFdestination_register == RFdump_idx))  RFdump_data = RFwrite_data;
`endif
  end

endmodule

// File: tb/tb_rf_param_dump.sv
// Directed + randomized bench for rf_param_dump against an array-based reference model.
module tb_rf_param_dump;

  localparam int XLEN = 32, NREGS = 32, AW = 5;
  localparam int SX = 16, SN = 8, SAW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [AW-1:0]   r1, r2, wa, didx;
  logic [XLEN-1:0] wd, d1, d2, ddata;
  logic            we, start, ready, dvalid, busy, done;

  logic [SAW-1:0]  s_r1, s_r2, s_wa, s_didx;
  logic [SX-1:0]   s_wd, s_d1, s_d2, s_ddata;
  logic            s_we, s_start, s_ready, s_dvalid, s_busy, s_done;

  logic [XLEN-1:0] model  [NREGS];
  logic [SX-1:0]   smodel [SN];

  int n_checks = 0;
  int n_fail   = 0;

  rf_param_dump dut (
    .clk(clk), .rst(rst),
    .RFregister1(r1), .RFregister2(r2), .RFdestination_register(wa),
    .RFwrite_data(wd), .RFwenable(we), .RFdata1(d1), .RFdata2(d2),
    .RFdump_start(start), .RFdump_ready(ready), .RFdump_valid(dvalid),
    .RFdump_idx(didx), .RFdump_data(ddata), .RFdump_busy(busy), .RFdump_done(done)
  );

  rf_param_dump #(.XLEN(SX), .NREGS(SN)) dut_small (
    .clk(clk), .rst(rst),
    .RFregister1(s_r1), .RFregister2(s_r2), .RFdestination_register(s_wa),
    .RFwrite_data(s_wd), .RFwenable(s_we), .RFdata1(s_d1), .RFdata2(s_d2),
    .RFdump_start(s_start), .RFdump_ready(s_ready), .RFdump_valid(s_dvalid),
    .RFdump_idx(s_didx), .RFdump_data(s_ddata), .RFdump_busy(s_busy), .RFdump_done(s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Value a read port must show for address a while a write (we_, wa_, wd_) is being presented.
  function automatic logic [31:0] exp_read(input int a, input logic we_, input int wa_,
                                           input logic [31:0] wd_);
    if (a == 0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (we_ && wa_ == a) return wd_;
`endif
    return model[a];
  endfunction

  task automatic write_reg(input int a, input logic [31:0] d);
    we = 1'b1; wa = AW'(a); wd = d; r1 = AW'(a);
    #1;
    check("same_cycle_rd", d1, exp_read(a, 1'b1, a, d));
    tick;
    if (a != 0) model[a] = d;
    we = 1'b0;
    #1;
    check("post_write_rd", d1, model[a]);
  endtask

  initial begin
    int exp_idx, beats, a;
    logic got_done, accepted, last_beat;

    rst = 1'b1; r1 = '0; r2 = '0; wa = '0; wd = '0; we = 1'b0; start = 1'b0; ready = 1'b0;
    s_r1 = '0; s_r2 = '0; s_wa = '0; s_wd = '0; s_we = 1'b0; s_start = 1'b0; s_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    for (int i = 0; i < SN; i++) smodel[i] = '0;
    we = 1'b1; wa = 5'd7; wd = 32'h1234_5678;
    tick;
    tick;
    we = 1'b0;

    // Reset state
    check("rst_valid", 32'(dvalid), 32'd0);
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_done",  32'(done),   32'd0);
    check("rst_idx",   32'(didx),   32'd0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < NREGS; i++) begin
      r1 = AW'(i); r2 = AW'(NREGS - 1 - i);
      #1;
      check("rst_rd1", d1, 32'd0);
      check("rst_rd2", d2, 32'd0);
    end

    // Register 0 is hardwired, then directed and random writes
    write_reg(0, 32'hDEAD_BEEF);
    write_reg(3, 32'd42);
    write_reg(31, 32'hFFFF_FFFF);
    r1 = 5'd3; r2 = 5'd31;
    #1;
    check("rd_reg3",  d1, 32'd42);
    check("rd_reg31", d2, 32'hFFFF_FFFF);
    repeat (30) write_reg(int'($urandom_range(0, 31)), $urandom);
    for (int i = 0; i < NREGS; i++) begin
      r2 = AW'(i);
      #1;
      check("rand_rd2", d2, model[i]);
    end

    // Dump with ready held high
    start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      check("dump_valid", 32'(dvalid), 32'd1);
      check("dump_idx",   32'(didx),   32'(k));
      check("dump_data",  ddata,       model[k]);
      tick;
    end
    check("dump_done_pulse", 32'(done),   32'd1);
    check("dump_done_busy",  32'(busy),   32'd1);
    check("dump_done_valid", 32'(dvalid), 32'd0);
    tick;
    check("dump_idle_busy", 32'(busy), 32'd0);
    check("dump_idle_done", 32'(done), 32'd0);

    // Dump with random stalls, stray start pulses and concurrent writes
    ready = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    exp_idx = 0; beats = 0; got_done = 1'b0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      ready = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      wa    = AW'($urandom_range(0, 31));
      wd    = $urandom;
      #1;
      check("tog_valid", 32'(dvalid), 32'd1);
      check("tog_busy",  32'(busy),   32'd1);
      check("tog_idx",   32'(didx),   32'(exp_idx));
      check("tog_data",  ddata,       exp_read(exp_idx, we, int'(wa), wd));
      accepted  = ready;
      last_beat = (exp_idx == NREGS - 1);
      tick;
      if (we && wa != '0) model[wa] = wd;
      if (accepted) begin
        beats++;
        if (last_beat) begin
          got_done = 1'b1;
          check("tog_done",       32'(done),   32'd1);
          check("tog_done_valid", 32'(dvalid), 32'd0);
        end else begin
          exp_idx++;
        end
      end
      if (!got_done) check("tog_no_early_done", 32'(done), 32'd0);
    end
    if (!got_done) check("tog_timeout", 32'd0, 32'd1);
    check("tog_beats", 32'(beats), 32'(NREGS));
    start = 1'b0; we = 1'b0; ready = 1'b0;
    tick;
    check("tog_idle_busy",  32'(busy),   32'd0);
    check("tog_idle_done",  32'(done),   32'd0);
    check("tog_idle_valid", 32'(dvalid), 32'd0);

    // Reset in the middle of a scan
    start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    check("mid_idx", 32'(didx), 32'd10);
    rst = 1'b1;
    tick;
    check("mid_rst_valid", 32'(dvalid), 32'd0);
    check("mid_rst_busy",  32'(busy),   32'd0);
    check("mid_rst_done",  32'(done),   32'd0);
    rst = 1'b0;
    tick;
    check("mid_rst_no_done", 32'(done), 32'd0);
    check("mid_rst_idle",    32'(busy), 32'd0);
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    for (int i = 0; i < NREGS; i++) begin
      r1 = AW'(i);
      #1;
      check("mid_rst_clear", d1, 32'd0);
    end

    // Narrow configuration: 16-bit data, 8 registers
    for (int i = 0; i < SN; i++) begin
      s_we = 1'b1; s_wa = SAW'(i); s_wd = SX'($urandom);
      tick;
      if (i != 0) smodel[i] = s_wd;
    end
    s_we = 1'b0;
    for (int i = 0; i < SN; i++) begin
      a = SN - 1 - i;
      s_r1 = SAW'(i); s_r2 = SAW'(a);
      #1;
      check("small_rd1", 32'(s_d1), 32'(smodel[i]));
      check("small_rd2", 32'(s_d2), 32'(smodel[a]));
    end
    s_start = 1'b1; s_ready = 1'b1;
    tick;
    s_start = 1'b0;
    for (int k = 0; k < SN; k++) begin
      check("small_valid", 32'(s_dvalid), 32'd1);
      check("small_idx",   32'(s_didx),   32'(k));
      check("small_data",  32'(s_ddata),  32'(smodel[k]));
      tick;
    end
    check("small_done", 32'(s_done),   32'd1);
    check("small_dv",   32'(s_dvalid), 32'd0);
    tick;
    check("small_idle", 32'(s_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
